// File: rtl/mem_loader.sv
// Boot loader: streams a length-prefixed, checksummed program image into
// program memory, clears the stack RAM, then releases the core to run.
module mem_loader #(
  parameter int PROG_AW  = 8,
  parameter int STACK_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        core_reset,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHK,
    S_CLEAR,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [PROG_AW-1:0]  P_ONE  = PROG_AW'(1);
  localparam logic [STACK_AW-1:0] S_ONE  = STACK_AW'(1);
  localparam logic [STACK_AW-1:0] S_LAST = '1;

  state_e              state_q, state_d;
  logic [PROG_AW-1:0]  len_q, len_d;
  logic [PROG_AW-1:0]  wptr_q, wptr_d;
  logic [STACK_AW-1:0] cptr_q, cptr_d;
  logic [7:0]          csum_q, csum_d;

  logic [7:0] prog_mem  [2**PROG_AW];
  logic [7:0] stack_mem [2**STACK_AW];

  logic                fire;
  logic                prog_we;
  logic                stack_we;
  logic [STACK_AW-1:0] stack_wa;
  logic [7:0]          stack_wd;
  logic                ab_unused;

  assign fire      = ld_valid && ld_ready;
  assign ab_unused = &{1'b0, AB};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      cptr_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    csum_d  = csum_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (ld_start) state_d = S_LEN;
      end
      S_LEN: begin
        if (fire) begin
          // length 0 wraps to a full 2^PROG_AW image via the pointer compare
          len_d   = PROG_AW'(ld_data);
          wptr_d  = '0;
          csum_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fire) begin
          wptr_d = wptr_q + P_ONE;
          csum_d = csum_q + ld_data;
          if (wptr_q == len_q - P_ONE) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (fire) begin
          cptr_d  = '0;
          state_d = (ld_data == csum_q) ? S_CLEAR : S_ERR;
        end
      end
      S_CLEAR: begin
        cptr_d = cptr_q + S_ONE;
        if (cptr_q == S_LAST) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready   = 1'b0;
    ld_busy    = 1'b0;
    ld_err     = 1'b0;
    core_reset = 1'b1;
    DI         = 8'h00;
    prog_we    = 1'b0;
    stack_we   = 1'b0;
    stack_wa   = cptr_q;
    stack_wd   = 8'h00;
    unique case (state_q)
      S_LEN: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        prog_we  = fire && !reset;
      end
      S_CHK: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
      end
      S_CLEAR: begin
        ld_busy  = 1'b1;
        stack_we = !reset;
      end
      S_RUN: begin
        core_reset = 1'b0;
        DI = AB[15] ? stack_mem[AB[STACK_AW-1:0]]
                    : prog_mem[AB[PROG_AW-1:0]];
        stack_we = WE && AB[15] && !reset;
        stack_wa = AB[STACK_AW-1:0];
        stack_wd = DO;
      end
      S_ERR: ld_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (prog_we) prog_mem[wptr_q] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (stack_we) stack_mem[stack_wa] <= stack_wd;
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed-plus-random bench for mem_loader, checked against an
// array model of program memory and stack built from the load rules.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        core_reset;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] prog_m  [256];
  logic [7:0] stack_m [256];

  always #5 clk = ~clk;

  mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .AB         (AB),
    .DO         (DO),
    .WE         (WE),
    .DI         (DI),
    .core_reset (core_reset),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_err     (ld_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic read(input string tag, input logic [15:0] a,
                      input logic [7:0] exp);
    AB = a;
    #1;
    check(tag, DI, exp);
  endtask

  task automatic wait_run(input int exp_cycles);
    int n;
    n = 0;
    while (core_reset && n < 1000) begin
      tick();
      n++;
    end
    check("clear_cycles", 8'(n == exp_cycles), 8'd1);
    check("run_core_reset", {7'd0, core_reset}, 8'd0);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    int k;
    int cyc;
    int a;
    reset = 1'b1; AB = 16'h0001; DO = 8'h00; WE = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      prog_m[i]  = 8'hxx;
      stack_m[i] = 8'h00;
    end
    tick(); tick();
    check("rst_core_reset", {7'd0, core_reset}, 8'd1);
    check("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
    check("rst_ld_busy", {7'd0, ld_busy}, 8'd0);
    check("rst_ld_err", {7'd0, ld_err}, 8'd0);
    check("rst_di", DI, 8'h00);
    reset = 1'b0;
    tick();

    // good load; ld_start arrives again with the length byte and is ignored
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check("len_ready", {7'd0, ld_ready}, 8'd1);
    check("len_busy", {7'd0, ld_busy}, 8'd1);
    ld_start = 1'b1; send(8'h03); ld_start = 1'b0;
    send(8'h11); send(8'h22); send(8'h33);
    prog_m[0] = 8'h11; prog_m[1] = 8'h22; prog_m[2] = 8'h33;
    check("chk_ready", {7'd0, ld_ready}, 8'd1);
    send(8'h66);
    check("clear_busy", {7'd0, ld_busy}, 8'd1);
    check("clear_ready", {7'd0, ld_ready}, 8'd0);
    wait_run(256);
    check("run_busy", {7'd0, ld_busy}, 8'd0);
    read("run_prog1", 16'h0001, 8'h22);
    read("run_stack5", 16'h8005, 8'h00);
    read("run_alias", 16'h7F02, 8'h33);

    // core writes: stack writable, program read-only
    AB = 16'h8010; DO = 8'hA5; WE = 1'b1; tick(); WE = 1'b0;
    stack_m[8'h10] = 8'hA5;
    read("stack_wr", 16'h8010, 8'hA5);
    AB = 16'h0002; DO = 8'hFF; WE = 1'b1; tick(); WE = 1'b0;
    read("prog_ro", 16'h0002, 8'h33);
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = 8'($urandom);
      AB = {1'b1, 7'($urandom), 8'(a)};
      DO = b; WE = 1'b1; tick(); WE = 1'b0;
      stack_m[a] = b;
    end
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, 255));
      read("stack_rand", {8'h80, 8'(a)}, stack_m[a]);
    end

    // restart from RUN, bad checksum
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check("restart_core_reset", {7'd0, core_reset}, 8'd1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h65);
    AB = 16'h0001;
    #1;
    check("err_ld_err", {7'd0, ld_err}, 8'd1);
    check("err_core_reset", {7'd0, core_reset}, 8'd1);
    check("err_di", DI, 8'h00);
    repeat (3) tick();
    check("err_sticky", {7'd0, ld_err}, 8'd1);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    check("err_exit", {7'd0, ld_err}, 8'd0);
    check("err_to_len", {7'd0, ld_ready}, 8'd1);

    // full 256-byte image, random valid gaps and stray ld_start
    send(8'h00);
    k = 0; cyc = 0; sum = 8'h00;
    while (k < 256 && cyc < 5000) begin
      ld_valid = 1'($urandom);
      ld_start = ($urandom_range(0, 9) == 0);
      b = 8'($urandom);
      ld_data = b;
      tick();
      if (ld_valid) begin
        prog_m[k] = b;
        sum = sum + b;
        k++;
      end
      cyc++;
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    check("full_count", 8'(k == 256), 8'd1);
    check("full_chk_state", {7'd0, ld_ready}, 8'd1);
    send(sum);
    wait_run(256);
    for (int i = 0; i < 256; i++) stack_m[i] = 8'h00;
    read("full_last", 16'h00FF, prog_m[255]);
    read("full_wrap", 16'h0100, prog_m[0]);
    read("stack_cleared", 16'h8010, stack_m[8'h10]);
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 255));
      read("full_rand", 16'(a), prog_m[a]);
    end

    // reset on the second LOAD byte aborts the load
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    send(8'h05);
    send(8'h5A);
    prog_m[0] = 8'h5A;
    ld_valid = 1'b1; ld_data = 8'hC3; reset = 1'b1; ld_start = 1'b1;
    tick();
    ld_valid = 1'b0; reset = 1'b0; ld_start = 1'b0;
    check("abort_busy", {7'd0, ld_busy}, 8'd0);
    check("abort_ready", {7'd0, ld_ready}, 8'd0);
    check("abort_core_reset", {7'd0, core_reset}, 8'd1);
    tick();
    check("abort_idle", {7'd0, ld_busy}, 8'd0);

    // short reload of prog[0] only, to expose prog[1..]
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    send(8'h01); send(8'h5A); send(8'h5A);
    wait_run(256);
    read("abort_prog0", 16'h0000, prog_m[0]);
    read("abort_prog1", 16'h0001, prog_m[1]);
    read("abort_prog2", 16'h0002, prog_m[2]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
